seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Time-multiplexed N-digit 7-segment driver; successor to the static two-display decoder, which copied one digit to both displays.
- Scans one digit per refresh slot with dead-time between slots.
- Latches new values tear-free at frame boundaries. Supports hex mode, per-digit blanking, leading-zero suppression and selectable segment/anode polarity.
- Sits between the core data path and the board display pins.

Parameters:
- N_DIGITS, 2, number of digits scanned (1..8).
- REFRESH_DIV, 27000, clocks per digit slot (27 MHz gives 1 kHz per digit); must exceed DEAD_CYCLES.
- DEAD_CYCLES, 2, clocks at the start of each slot with all anodes off (anti-ghosting, >=1).
- HEX_MODE, 0, 1 = show codes 10..15 as A b C d E F; 0 = blank them.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_o (common-anode parts).
- AN_ACTIVE_LOW, 1, 1 inverts an_o.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  scan enable.
- load_i  in  1  capture digits_i/blank_i/lz_i into the pending register this cycle.
- digits_i  in  4*N_DIGITS  BCD/hex nibbles; digit 0 = bits [3:0] = least significant.
- blank_i  in  N_DIGITS  per-digit force-off.
- lz_i  in  1  leading-zero suppression enable.
- seg_o  out  7  {a,b,c,d,e,f,g}, a = MSB; registered.
- an_o  out  N_DIGITS  digit select, bit k = digit k; registered.
- frame_done_o  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - seg_o and an_o at inactive levels (all segments off, all anodes off, after polarity).
  - frame_done_o = 0.
  - Slot counter cnt = 0, digit index idx = 0.
  - Pending and shadow registers = 0, with blank bits = all 1.
  - State = IDLE.
- Reset mid-scan returns to exactly these values asynchronously.
- States:
  - IDLE: enable_i = 0; outputs inactive; cnt = 0, idx = 0.
  - DEAD: cnt < DEAD_CYCLES; anodes off; seg_o off.
  - ON: cnt >= DEAD_CYCLES; an_o selects idx; seg_o shows decoded shadow digit idx.
- Transitions:
  - IDLE -> DEAD on enable_i = 1; the first active cycle is slot 0, cnt 0.
  - cnt increments each clock. At cnt = REFRESH_DIV-1, cnt wraps to 0, idx advances, and state returns to DEAD.
  - idx wraps from N_DIGITS-1 to 0.
  - Any state -> IDLE when enable_i = 0 (takes effect next clock).
- Output latency: outputs are registered and reflect the state/cnt/idx of the previous cycle (one clock of latency).
- Load and shadow update:
  - load_i captures into pending every cycle it is high; the last load wins.
  - pending -> shadow on the clock where idx wraps N_DIGITS-1 -> 0 (frame boundary), or immediately on the next clock while in IDLE.
  - A load asserted on the same cycle as the wrap is captured into pending and reaches shadow at the following frame boundary. It must never tear a frame.
- frame_done_o: high for exactly one clock, on the cycle after cnt = REFRESH_DIV-1 with idx = N_DIGITS-1.
- Decode:
  - 0..9 use the standard patterns: 0 = 1111110, 1 = 0110000, ..., 8 = 1111111, 9 = 1111011.
  - With HEX_MODE = 1: A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.
  - With HEX_MODE = 0, codes 10..15 give all segments off.
- Blanking:
  - A digit is off if its shadow blank bit is 1.
  - With lz: a digit k > 0 is off if it and all higher digits equal 0. Digit 0 is never suppressed.
  - A blanked digit still gets its slot: an_o is asserted and seg_o is all off.
- Polarity: applied last; internal logic is active-high.

Test Plan:
- Bench config: N_DIGITS = 2, REFRESH_DIV = 8, DEAD_CYCLES = 2, active-high both.
- Reset and idle: assert rst mid-slot -> seg_o = 0000000 and an_o = 00 immediately. With enable_i = 0 -> no anode activity for 100 clocks.
- Basic scan: load digits = 0x42, enable -> per slot, 2 clocks with an_o = 00, then 6 clocks with an_o = 01 and seg_o = 1101101; then 2 off, then 6 clocks with an_o = 10 and seg_o = 0110011. frame_done_o pulses every 16 clocks.
- Tear-free load: load 0x42, then load 0x97 in the middle of the digit-0 slot -> the current frame still shows 4 on digit 1; the next frame shows 9 / 7. A load on the wrap cycle appears one frame later.
- Hex/blank: HEX_MODE = 1, digits = 0xAF -> 1110111 / 1000111. HEX_MODE = 0 -> both digits off with an_o still scanning. blank_i = 01 -> digit 0 off.
- Leading zeros: lz_i = 1, digits = 0x05 -> digit 1 off, digit 0 = 1011011. digits = 0x00 -> digit 0 = 1111110.
- Polarity: SEG_ACTIVE_LOW = 1 and AN_ACTIVE_LOW = 1 -> reset shows seg_o = 1111111, an_o = 11. Digit 8 in its ON phase -> seg_o = 0000000, an_o = 10 (digit 0, active low).

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: one digit per refresh slot with
// leading dead-time, frame-boundary shadow latching, hex/blank/lz decode and output polarity.
module seg_scan_driver #(
  parameter int N_DIGITS       = 2,
  parameter int REFRESH_DIV    = 27000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit HEX_MODE       = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   digits_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic                    lz_i,
  output logic [6:0]              seg_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_done_o,
  output logic [1:0]              dbg_state
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [IW-1:0] idx_q, idx_n;
  logic          frame_wrap;

  logic [4*N_DIGITS-1:0] pend_digits, shadow_digits;
  logic [N_DIGITS-1:0]   pend_blank, shadow_blank;
  logic                  pend_lz, shadow_lz;

  logic [3:0]            sh_nib [N_DIGITS];
  logic [N_DIGITS-1:0]   digit_off;
  logic [N_DIGITS-1:0]   an_sel;
  logic [3:0]            cur_nib;
  logic                  cur_off;
  logic [6:0]            seg_act;
  logic [N_DIGITS-1:0]   an_act;

  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  fd_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: p = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC: p = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD: p = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE: p = HEX_MODE ? 7'b1001111 : 7'b0000000;
      4'hF: p = HEX_MODE ? 7'b1000111 : 7'b0000000;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Scan sequencer: DEAD for the first DEAD_CYCLES of a slot, ON for the rest.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    idx_n      = idx_q;
    frame_wrap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (enable_i) state_n = ST_DEAD;
      end
      ST_DEAD, ST_ON: begin
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_n      = '0;
          state_n    = ST_DEAD;
          frame_wrap = (idx_q == IDX_LAST);
          idx_n      = frame_wrap ? '0 : idx_q + IW'(1);
        end else if (state_q == ST_DEAD && cnt_q == DEAD_LAST) begin
          state_n = ST_ON;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (!enable_i) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
    end
  end

  // Pending takes every load; shadow only moves at a frame boundary or while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_digits   <= '0;
      pend_blank    <= '1;
      pend_lz       <= 1'b0;
      shadow_digits <= '0;
      shadow_blank  <= '1;
      shadow_lz     <= 1'b0;
    end else begin
      if (load_i) begin
        pend_digits <= digits_i;
        pend_blank  <= blank_i;
        pend_lz     <= lz_i;
      end
      if (state_q == ST_IDLE || frame_wrap) begin
        shadow_digits <= pend_digits;
        shadow_blank  <= pend_blank;
        shadow_lz     <= pend_lz;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) sh_nib[k] = shadow_digits[4*k +: 4];
  end

  // zero_run stays high while every digit from the top down to k is zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    digit_off = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (sh_nib[k] == 4'd0);
      digit_off[k] = shadow_blank[k] | (shadow_lz & zero_run & (k != 0));
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_off = 1'b1;
    an_sel  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = sh_nib[k];
        cur_off   = digit_off[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  // A blanked digit keeps its anode slot but drives no segments.
  always_comb begin
    seg_act = 7'b0000000;
    an_act  = '0;
    if (state_q == ST_ON) begin
      an_act  = an_sel;
      seg_act = cur_off ? 7'b0000000 : decode(cur_nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_act ^ SEG_OFF;
      an_q  <= an_act ^ AN_OFF;
      fd_q  <= (state_q == ST_ON) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = fd_q;
  assign dbg_state    = state_q;

endmodule
